// File: rtl/imm_gen_pipe_pkg.sv
// Purpose: opcode constants, immediate class enum and class decoder for imm_gen_pipe.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package imm_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LONG_IMM = 5'b11000;
  localparam logic [OPC_W-1:0] OP_SHORT_0  = 5'b11001;
  localparam logic [OPC_W-1:0] OP_SHORT_1  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_SHORT_2  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_SHORT_3  = 5'b10010;

  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_SHORT = 2'd1,
    IMM_LONG  = 2'd2
  } imm_class_t;

  // Map an opcode to the immediate field it carries (if any).
  function automatic imm_class_t imm_class(input logic [OPC_W-1:0] op);
    imm_class_t c;
    case (op)
      OP_LONG_IMM: c = IMM_LONG;
      OP_SHORT_0,
      OP_SHORT_1,
      OP_SHORT_2,
      OP_SHORT_3:  c = IMM_SHORT;
      default:     c = IMM_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_fifo.sv
// Purpose: generic synchronous FIFO with occupancy count, power-of-two depth.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: wr_ready_o = not full (independent of rd_ready_i); rd_valid_o = not empty.
module imm_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign wr_ready_o = (count_q < CW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_valid_o & rd_ready_i;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Control state; storage itself is left unreset because it is never read while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the incoming entry at the tail.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: decode opcode class, extend the selected field to XLEN, broadcast low lane across SIMD lanes.
// Latency: 1 cycle from accepted input to output head (empty queue), one result per cycle sustained.
// Backpressure: DEPTH-entry queue; in_ready = queue not full, never combinational on out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OPW   = 5,
  parameter int FA_W  = 5,
  parameter int FB_W  = 10,
  parameter int LANES = 4,
  parameter int LANEW = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         opcode,
  input  logic [FA_W-1:0]        field_a,
  input  logic [FB_W-1:0]        field_b,
  input  logic                   sext_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPW-1:0]         out_opcode,
  output logic [XLEN-1:0]        out_imm,
  output logic [LANES*LANEW-1:0] out_vimm,
  output logic                   out_imm_used,
  output logic [15:0]            imm_count
);

  localparam int EW = OPW + 1 + XLEN;
  localparam int CW = $clog2(DEPTH) + 1;

  imm_class_t       cls;
  logic [XLEN-1:0]  imm_dec;
  logic             used_dec;
  logic [EW-1:0]    head;
  logic [CW-1:0]    fifo_count;
  logic             pop;
  logic [15:0]      imm_count_q, imm_count_d;

  // Input-side decode: pick the field for this class and zero/sign-extend it.
  always_comb begin
    cls      = imm_class(opcode);
    imm_dec  = '0;
    used_dec = 1'b0;
    case (cls)
      IMM_LONG: begin
        used_dec              = 1'b1;
        imm_dec               = {XLEN{sext_en & field_b[FB_W-1]}};
        imm_dec[FB_W-1:0]     = field_b;
      end
      IMM_SHORT: begin
        used_dec              = 1'b1;
        imm_dec               = {XLEN{sext_en & field_a[FA_W-1]}};
        imm_dec[FA_W-1:0]     = field_a;
      end
      default: begin
        used_dec = 1'b0;
        imm_dec  = '0;
      end
    endcase
  end

  imm_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  ({opcode, used_dec, imm_dec}),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (head),
    .count_o    (fifo_count)
  );

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign out_opcode   = out_valid ? head[EW-1 -: OPW] : '0;
  assign out_imm_used = out_valid ? head[XLEN]        : 1'b0;
  assign out_imm      = out_valid ? head[XLEN-1:0]    : '0;
  assign out_vimm     = {LANES{out_imm[LANEW-1:0]}};

  assign pop = out_valid & out_ready;

  // Count delivered immediate-bearing entries, sticking at all-ones.
  always_comb begin
    imm_count_d = imm_count_q;
    if (pop && out_imm_used && (imm_count_q != 16'hFFFF))
      imm_count_d = imm_count_q + 16'd1;
  end

  // Delivered-immediate counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) imm_count_q <= '0;
    else     imm_count_q <= imm_count_d;
  end

  assign imm_count = imm_count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose: randomized and directed self-checking bench for imm_gen_pipe against a queue model.
// Latency: model expects head visible the cycle after acceptance.
// Backpressure: model accepts only while it holds fewer than DEPTH entries.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  opcode = '0;
  logic [4:0]  field_a = '0;
  logic [9:0]  field_b = '0;
  logic        sext_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_opcode;
  logic [31:0] out_imm;
  logic [31:0] out_vimm;
  logic        out_imm_used;
  logic [15:0] imm_count;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .field_a      (field_a),
    .field_b      (field_b),
    .sext_en      (sext_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_imm      (out_imm),
    .out_vimm     (out_vimm),
    .out_imm_used (out_imm_used),
    .imm_count    (imm_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] imm;
    logic        used;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;

  // Expected entry straight from the opcode table and extension rule.
  function automatic ent_t mk(logic [4:0] op, logic [4:0] fa, logic [9:0] fb, logic sx);
    ent_t e;
    e.op = op;
    e.used = 1'b1;
    if (op == 5'b11000)
      e.imm = sx ? 32'($signed(fb)) : 32'(fb);
    else if (op inside {5'b11001, 5'b10001, 5'b10011, 5'b10010})
      e.imm = sx ? 32'($signed(fa)) : 32'(fa);
    else begin
      e.imm = 32'd0;
      e.used = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted entries; pop head then append on each clock.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      bit acc, pp;
      acc = in_valid && (q.size() < DEPTH);
      pp  = out_ready && (q.size() != 0);
      if (pp) begin
        if (q[0].used && mcnt < 65535) mcnt++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(mk(opcode, field_a, field_b, sext_en));
    end
  end

  // Compare process: every falling edge the visible outputs must match the model.
  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
    chk("imm_count", 64'(imm_count), 64'(mcnt));
    if (q.size() != 0) begin
      chk("out_opcode", 64'(out_opcode),   64'(q[0].op));
      chk("out_imm",    64'(out_imm),      64'(q[0].imm));
      chk("out_used",   64'(out_imm_used), 64'(q[0].used));
      chk("out_vimm",   64'(out_vimm),     64'({4{q[0].imm[7:0]}}));
    end else begin
      chk("empty_imm",  64'(out_imm),  64'd0);
      chk("empty_vimm", 64'(out_vimm), 64'd0);
    end
  end

  task automatic drive(logic v, logic [4:0] op, logic [4:0] fa, logic [9:0] fb, logic sx);
    in_valid = v;
    opcode   = op;
    field_a  = fa;
    field_b  = fb;
    sext_en  = sx;
  endtask

  // Present one instruction for exactly one edge (queue assumed not full), then idle.
  task automatic push_one(logic [4:0] op, logic [4:0] fa, logic [9:0] fb, logic sx);
    @(posedge clk); #1;
    drive(1'b1, op, fa, fb, sx);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] c0;
    ent_t e;

    // Reset state.
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_imm_count", 64'(imm_count), 64'd0);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    #10 rst = 1'b0;
    out_ready = 1'b1;

    // Single long push, zero-extended.
    push_one(5'b11000, 5'd0, 10'h3FF, 1'b0);
    chk("long_valid", 64'(out_valid),    64'd1);
    chk("long_imm",   64'(out_imm),      64'h0000_03FF);
    chk("long_vimm",  64'(out_vimm),     64'hFFFF_FFFF);
    chk("long_used",  64'(out_imm_used), 64'd1);

    // Short field, sign- and zero-extended.
    push_one(5'b10011, 5'b10110, 10'h000, 1'b1);
    chk("sext_imm",  64'(out_imm),  64'hFFFF_FFF6);
    chk("sext_vimm", 64'(out_vimm), 64'hF6F6_F6F6);
    push_one(5'b10011, 5'b10110, 10'h000, 1'b0);
    chk("zext_imm",  64'(out_imm),  64'h0000_0016);
    chk("zext_vimm", 64'(out_vimm), 64'h1616_1616);

    // NONE class ignores sext_en and does not count.
    push_one(5'b00000, 5'h1F, 10'h3FF, 1'b1);
    c0 = imm_count;
    chk("none_imm",  64'(out_imm),      64'd0);
    chk("none_used", 64'(out_imm_used), 64'd0);
    @(negedge clk);
    chk("none_count", 64'(imm_count), 64'(c0));

    // Backpressure: three back-to-back offers with out_ready low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 5'b11000, 5'd0, 10'h155, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 5'b11001, 5'h0A, 10'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 5'b10001, 5'h11, 10'd0, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head",     64'(out_imm),  64'h155);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_hold", 64'(out_imm), 64'h155);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_held", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    chk("bp_second",        64'(out_imm),  64'hA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", 64'(out_imm), 64'hFFFF_FFF1);
    repeat (2) @(posedge clk);

    // Streaming 100 immediate-bearing instructions after a fresh reset.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      drive(1'b1, ($urandom_range(0, 4) == 0) ? 5'b11000 :
                  ((i % 2) ? 5'b10010 : 5'b11001),
            5'($urandom), 10'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stream_count", 64'(imm_count), 64'd100);

    // Random traffic: any opcode, random valid/ready.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
            10'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Async reset with two entries queued, asserted away from any edge.
    @(posedge clk); #1;
    drive(1'b1, 5'b11000, 5'd0, 10'h001, 1'b0);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(imm_count), 64'd0);
    chk("arst_ready", 64'(in_ready),  64'd1);
    #4 rst = 1'b0;
    out_ready = 1'b1;
    e = mk(5'b10010, 5'h13, 10'd0, 1'b1);
    push_one(5'b10010, 5'h13, 10'd0, 1'b1);
    chk("post_rst_imm", 64'(out_imm), 64'(e.imm));
    chk("post_rst_lit", 64'(out_imm), 64'hFFFF_FFF3);

    // Saturation: long full-rate run from a cleared counter.
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 5'b11000, 5'd0, 10'h2AA, 1'b1);
    repeat (65545) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_count", 64'(imm_count), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the SIMD AES core.
- Decodes opcode class, then extracts and zero- or sign-extends the matching instruction field to XLEN.
- Replicates the low LANEW bits of the result across LANES vector lanes, for SIMD immediates such as round-key byte splats.
- A small FIFO with valid/ready handshakes on both sides absorbs execute-stage stalls without dropping or duplicating instructions.

Parameters:
XLEN, 32, scalar immediate width (>= FB_W)
OPW, 5, opcode width
FA_W, 5, short-field (P1) width
FB_W, 10, long-field (P2) width
LANES, 4, SIMD lane count for broadcast output
LANEW, 8, lane width (LANEW <= XLEN)
DEPTH, 2, output FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
opcode  in  OPW  instruction opcode, MSB first
field_a  in  FA_W  short immediate field
field_b  in  FB_W  long immediate field
sext_en  in  1  1 = sign-extend selected field, 0 = zero-extend
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_opcode  out  OPW  opcode travelling with immediate
out_imm  out  XLEN  scalar immediate
out_vimm  out  LANES*LANEW  lane broadcast of out_imm[LANEW-1:0]; lane 0 = least significant slice
out_imm_used  out  1  opcode class uses an immediate
imm_count  out  16  saturating count of immediate-bearing instructions delivered

Behaviour:
- Opcode classes (combinational decode on input side):
  - LONG: 11000. Selects field_b.
  - SHORT: 11001, 10001, 10011, 10010. Selects field_a.
  - NONE: all other opcodes. imm = 0, used = 0.
- Extension:
  - sext_en=0: zero-fill to XLEN.
  - sext_en=1: replicate field MSB (field_b[FB_W-1] or field_a[FA_W-1]) into the upper bits.
  - NONE class always yields 0 regardless of sext_en.
- Broadcast: out_vimm = LANES copies of out_imm[LANEW-1:0]. Purely combinational from the FIFO head; adds no latency.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count < DEPTH); it does not depend combinationally on out_ready.
  - out_valid = (count != 0).
- Latency: pushed in cycle N; out_valid and data visible in cycle N+1 at the earliest (empty FIFO). Full throughput of one per cycle when out_ready is held high.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when full: in_ready=0, so only the pop occurs.
  - Simultaneous push and pop when non-empty and non-full: count unchanged, both pointers advance.
  - Push alone when count=DEPTH is impossible by construction.
  - Pop alone when empty is impossible because out_valid=0.
- Output stability: while out_valid=1 and out_ready=0, out_opcode, out_imm, out_vimm and out_imm_used hold their values.
- imm_count: increments on a pop whose entry has used=1. Saturates at 16'hFFFF and never wraps.
- Reset: asynchronous. Pointers, count and imm_count are cleared; out_valid=0, in_ready=1.
  - Storage contents are don't-care, but the data outputs must read 0 while empty: data is gated with out_valid.
  - Reset mid-transfer discards all queued entries; the first valid output after release comes from a post-release push.

Decomposition:
- Package imm_pkg holds:
  - opcode constants OP_LONG_IMM=11000, OP_SHORT_0=11001, OP_SHORT_1=10001, OP_SHORT_2=10011, OP_SHORT_3=10010;
  - enum imm_class_t {IMM_NONE, IMM_SHORT, IMM_LONG};
  - function imm_class(opcode).
- One sub-module, imm_fifo (parametrised width/DEPTH sync FIFO with count). Decode and extension stay in the top level.

Test Plan:
- Reset then single push: opcode=11000, field_b=10'h3FF, sext_en=0 -> one cycle later out_valid=1, out_imm=32'h000003FF, out_vimm=32'hFFFFFFFF, out_imm_used=1.
- Sign extension: opcode=10011, field_a=5'b10110, sext_en=1 -> out_imm=32'hFFFFFFF6, out_vimm=32'hF6F6F6F6. With sext_en=0 -> 32'h00000016, out_vimm=32'h16161616.
- NONE class: opcode=00000, field_a=5'h1F, sext_en=1 -> out_imm=0, out_imm_used=0, imm_count unchanged after pop.
- Backpressure: out_ready=0 while pushing 3 instructions back-to-back -> in_ready drops after 2 accepted, outputs hold entry 0. Release out_ready -> entries emerge in order, no loss or duplication, in_ready returns 1 the cycle after the first pop.
- Streaming: out_ready=1, 100 consecutive SHORT/LONG pushes -> one output per cycle, 1-cycle latency, imm_count=100. Preset imm_count near 16'hFFFF via a long run -> saturates at 16'hFFFF.
- Async reset asserted mid-cycle with 2 entries queued -> out_valid=0 and imm_count=0 immediately, without waiting for a clock edge. After release, the first output equals the first post-reset push.
